fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage that feeds the decode stage of the MIPS pipeline.
- Holds the fetch PC and issues one-outstanding requests to instruction memory.
- Buffers returned {pc, instruction} pairs in a small queue.
- Redirects on a taken branch/jump signalled by the execute stage, discarding stale instructions.

Parameters:
PC_WIDTH, 32, width of PC and memory address
IWIDTH, 32, instruction width
DEPTH, 2, instruction queue entries (power of two, >=2)
PC_INC, 4, byte increment per sequential fetch
RESET_PC, 0, fetch PC after reset

Ports:
fs_clk  in  1  clock, rising edge
fs_rst  in  1  asynchronous active-low reset
fs_i_ce  in  1  fetch enable; low blocks new requests
fs_i_change_pc  in  1  redirect strobe from execute stage
fs_i_alu_pc  in  PC_WIDTH  redirect target, valid with fs_i_change_pc
fs_i_stall  in  1  decode cannot accept this cycle
fs_o_imem_req  out  1  memory request, held until ack
fs_o_imem_addr  out  PC_WIDTH  request address, stable while req high
fs_i_imem_ack  in  1  memory returns data; sampled only while req high
fs_i_imem_data  in  IWIDTH  instruction, valid with ack
fs_o_valid  out  1  queue head valid
fs_o_pc  out  PC_WIDTH  PC of head instruction
fs_o_instr  out  IWIDTH  head instruction
fs_o_flush  out  1  one-cycle pulse to decode, cycle after a redirect

Behaviour:
- Interface: one clock (fs_clk). fs_rst is asynchronous, active-low.
- Reset values:
  - fetch_pc = RESET_PC; imem_addr = RESET_PC.
  - State IDLE; queue empty.
  - valid, req and flush all 0; fs_o_pc and fs_o_instr are 0.
- States:
  - IDLE: req=0.
  - REQ: req=1, addr = pending address.
  - DROP: req=1, addr = old pending address, returned data discarded.
- IDLE -> REQ: fs_i_ce=1, no redirect, and count < DEPTH. Latch pending addr = fetch_pc.
- In REQ, on ack:
  - Push {addr, data}; fetch_pc += PC_INC (wraps modulo 2^PC_WIDTH).
  - Stay in REQ with the new addr if ce=1 and free space remains after this cycle's push/pop. Otherwise go to IDLE.
  - Zero-wait memory (ack in the first req cycle) gives 1 instruction/cycle throughput.
- Redirect (fs_i_change_pc=1) has highest priority:
  - Queue is cleared the same edge; fetch_pc <= fs_i_alu_pc; fs_o_flush=1 next cycle only.
  - REQ without ack -> DROP.
  - REQ with ack in the same cycle: data discarded -> IDLE.
  - IDLE stays IDLE; the next request uses the target the cycle after.
- DROP: hold req/addr until ack, discard data, -> IDLE. A new redirect in DROP only updates fetch_pc.
- Queue output:
  - Registered; a pushed entry appears on fs_o_valid the cycle after ack.
  - Head pops when fs_o_valid=1 and fs_i_stall=0.
  - Pop and push in the same cycle are allowed when full.
  - Redirect overrides stall, push and pop.
- fs_i_ce low: no new request starts; an outstanding request completes normally; the queue still drains.
- The queue is never overrun: a request is issued only if count + outstanding <= DEPTH after the current pop.
- fs_o_pc/fs_o_instr hold their last value when fs_o_valid=0.

Test Plan:
- Reset: assert fs_rst=0 for 2 cycles -> req=0, valid=0, addr=0. After release with ce=1, req=1 with addr=0.
- Zero-wait stream: memory acks every req cycle, data=PC+0x100, no stall -> fs_o_valid continuous from 2nd cycle; fs_o_pc = 0,4,8,12 with matching instr.
- Backpressure:
  - Hold fs_i_stall=1 -> after 2 pushes, req drops and head stays pc=0.
  - Release stall -> pc=0,4,8 emitted in order, no loss or duplicate.
- Redirect with outstanding: ack latency 3, fs_i_change_pc=1 with alu_pc=0x40 while in REQ for addr 8.
  - Queue empties and flush pulses one cycle.
  - Ack for addr 8 is discarded.
  - Next req addr=0x40; first valid output pc=0x40.
- Simultaneous redirect+ack and redirect+stall: ack for addr 4 in the same cycle as redirect to 0x80 -> addr 4 never appears; next fetch 0x80. Repeat with stall=1 -> same result.
- Enable/wrap/reset mid-op:
  - ce=0 mid-REQ -> current ack is accepted, then req stays 0.
  - redirect to 2^PC_WIDTH-4 -> next pc wraps to 0.
  - fs_rst=0 asserted during REQ -> all outputs clear immediately (async).

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS fetch PC, one-outstanding imem requests and a small {pc, instr} queue toward decode
module fetch_stage #(
    parameter int PC_WIDTH = 32,
    parameter int IWIDTH = 32,
    parameter int DEPTH = 2,
    parameter int PC_INC = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                fs_clk,
    input  logic                fs_rst,
    input  logic                fs_i_ce,
    input  logic                fs_i_change_pc,
    input  logic [PC_WIDTH-1:0] fs_i_alu_pc,
    input  logic                fs_i_stall,
    output logic                fs_o_imem_req,
    output logic [PC_WIDTH-1:0] fs_o_imem_addr,
    input  logic                fs_i_imem_ack,
    input  logic [IWIDTH-1:0]   fs_i_imem_data,
    output logic                fs_o_valid,
    output logic [PC_WIDTH-1:0] fs_o_pc,
    output logic [IWIDTH-1:0]   fs_o_instr,
    output logic                fs_o_flush
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t state, state_nx;
    logic [PC_WIDTH-1:0] fetch_pc, fetch_pc_nx, addr, addr_nx, pc_seq;
    logic [PC_WIDTH-1:0] q_pc [DEPTH];
    logic [IWIDTH-1:0] q_instr [DEPTH];
    logic [AW-1:0] rptr, wptr, rptr_nx;
    logic [AW:0] count, count_pop, count_nx;
    logic push, pop;

    assign fs_o_valid = count != '0;
    assign fs_o_imem_req = state != IDLE;
    assign fs_o_imem_addr = addr;
    assign pc_seq = fetch_pc + PC_WIDTH'(PC_INC);
    assign push = state == REQ && fs_i_imem_ack && !fs_i_change_pc;
    assign pop = fs_o_valid && !fs_i_stall && !fs_i_change_pc;
    assign count_pop = count - (AW+1)'(pop);
    assign count_nx = fs_i_change_pc ? '0 : count_pop + (AW+1)'(push);
    assign rptr_nx = rptr + AW'(pop);

    // A redirect with the request still unanswered must wait out the stale ack in DROP
    always_comb begin
        state_nx = state;
        fetch_pc_nx = fetch_pc;
        addr_nx = addr;
        if (fs_i_change_pc) begin
            fetch_pc_nx = fs_i_alu_pc;
            state_nx = (state != IDLE && !fs_i_imem_ack) ? DROP : IDLE;
        end else if (state == IDLE) begin
            state_nx = (fs_i_ce && count < FULL) ? REQ : IDLE;
            addr_nx = (fs_i_ce && count < FULL) ? fetch_pc : addr;
        end else if (fs_i_imem_ack) begin
            state_nx = (state == REQ && fs_i_ce && count_nx < FULL) ? REQ : IDLE;
            fetch_pc_nx = state == REQ ? pc_seq : fetch_pc;
            addr_nx = state == REQ ? pc_seq : addr;
        end
    end

    always_ff @(posedge fs_clk or negedge fs_rst) begin
        if (!fs_rst) begin
            state <= IDLE;
            fetch_pc <= RESET_PC;
            addr <= RESET_PC;
            rptr <= '0;
            wptr <= '0;
            count <= '0;
            fs_o_flush <= 1'b0;
            fs_o_pc <= '0;
            fs_o_instr <= '0;
        end else begin
            state <= state_nx;
            fetch_pc <= fetch_pc_nx;
            addr <= addr_nx;
            rptr <= fs_i_change_pc ? wptr : rptr_nx;
            wptr <= wptr + AW'(push);
            count <= count_nx;
            fs_o_flush <= fs_i_change_pc;
            if (count_pop != '0) begin
                fs_o_pc <= q_pc[rptr_nx];
                fs_o_instr <= q_instr[rptr_nx];
            end else if (push) begin
                fs_o_pc <= addr;
                fs_o_instr <= fs_i_imem_data;
            end
        end
    end

    always_ff @(posedge fs_clk) begin
        if (push) begin
            q_pc[wptr] <= addr;
            q_instr[wptr] <= fs_i_imem_data;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with a latency-programmable instruction memory
module tb_fetch_stage;
    logic fs_clk = 1'b0;
    logic fs_rst = 1'b0;
    logic fs_i_ce = 1'b0;
    logic fs_i_change_pc = 1'b0;
    logic fs_i_stall = 1'b0;
    logic fs_i_imem_ack;
    logic [31:0] fs_i_alu_pc = '0;
    logic [31:0] fs_i_imem_data;
    logic fs_o_imem_req, fs_o_valid, fs_o_flush;
    logic [31:0] fs_o_imem_addr, fs_o_pc, fs_o_instr;

    typedef struct packed {logic [31:0] pc; logic [31:0] instr;} ent_t;
    ent_t sb[$];
    ent_t sb_e;
    logic [31:0] exp_addr = '0;
    logic dropping = 1'b0;
    int errors = 0;
    int checks = 0;
    int mem_lat = 0;
    int mem_cnt = 0;

    fetch_stage dut (
        .fs_clk(fs_clk), .fs_rst(fs_rst), .fs_i_ce(fs_i_ce),
        .fs_i_change_pc(fs_i_change_pc), .fs_i_alu_pc(fs_i_alu_pc), .fs_i_stall(fs_i_stall),
        .fs_o_imem_req(fs_o_imem_req), .fs_o_imem_addr(fs_o_imem_addr),
        .fs_i_imem_ack(fs_i_imem_ack), .fs_i_imem_data(fs_i_imem_data),
        .fs_o_valid(fs_o_valid), .fs_o_pc(fs_o_pc), .fs_o_instr(fs_o_instr), .fs_o_flush(fs_o_flush)
    );

    always #5 fs_clk = ~fs_clk;

    // Memory answers after mem_lat waiting cycles with data = addr + 0x100
    initial begin
        fs_i_imem_ack = 1'b0;
        fs_i_imem_data = '0;
        forever begin
            @(posedge fs_clk);
            #2;
            if (!fs_rst || !fs_o_imem_req) begin
                fs_i_imem_ack = 1'b0;
                mem_cnt = 0;
            end else if (mem_cnt >= mem_lat) begin
                fs_i_imem_ack = 1'b1;
                fs_i_imem_data = fs_o_imem_addr + 32'h100;
                mem_cnt = 0;
            end else begin
                fs_i_imem_ack = 1'b0;
                mem_cnt++;
            end
        end
    end

    // Scoreboard: accepted acks push the expected entry, decode pops are compared in order
    initial forever begin
        @(negedge fs_clk);
        if (!fs_rst) begin
            sb.delete();
            exp_addr = '0;
            dropping = 1'b0;
        end else begin
            if (fs_o_valid && !fs_i_stall && !fs_i_change_pc) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: got pc=%h instr=%h, want no entry", fs_o_pc, fs_o_instr);
                end else begin
                    sb_e = sb.pop_front();
                    if (fs_o_pc !== sb_e.pc || fs_o_instr !== sb_e.instr) begin
                        errors++;
                        $display("FAIL sb_head: got pc=%h instr=%h, want pc=%h instr=%h", fs_o_pc, fs_o_instr, sb_e.pc, sb_e.instr);
                    end
                end
            end
            if (fs_o_imem_req && fs_i_imem_ack && !dropping) begin
                checks++;
                if (fs_o_imem_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL sb_addr: got %h want %h", fs_o_imem_addr, exp_addr);
                end
            end
            if (fs_i_change_pc) begin
                sb.delete();
                exp_addr = fs_i_alu_pc;
                dropping = fs_o_imem_req && !fs_i_imem_ack;
            end else if (fs_o_imem_req && fs_i_imem_ack) begin
                if (!dropping) begin
                    sb.push_back('{exp_addr, exp_addr + 32'h100});
                    exp_addr += 4;
                end
                dropping = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want finish before 100000");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input logic ce, input logic st, input int lat);
        @(posedge fs_clk);
        #1;
        fs_rst = 1'b0;
        fs_i_change_pc = 1'b0;
        fs_i_ce = ce;
        fs_i_stall = st;
        mem_lat = lat;
        @(posedge fs_clk);
        #1;
        fs_rst = 1'b1;
    endtask

    task automatic test_reset();
        mem_lat = 0;
        fs_rst = 1'b1;
        #1;
        fs_rst = 1'b0;
        repeat (2) @(negedge fs_clk);
        checks++; if (fs_o_imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", fs_o_imem_req); end
        checks++; if (fs_o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", fs_o_valid); end
        checks++; if (fs_o_flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", fs_o_flush); end
        checks++; if (fs_o_imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", fs_o_imem_addr); end
        checks++; if (fs_o_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", fs_o_pc); end
        checks++; if (fs_o_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", fs_o_instr); end
        @(posedge fs_clk);
        #1;
        fs_rst = 1'b1;
        fs_i_ce = 1'b1;
        @(posedge fs_clk);
        @(negedge fs_clk);
        checks++; if (fs_o_imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", fs_o_imem_req); end
        checks++; if (fs_o_imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h want 0", fs_o_imem_addr); end
    endtask

    task automatic test_zero_wait();
        for (int i = 0; i < 4; i++) begin
            @(negedge fs_clk);
            checks++; if (fs_o_valid !== 1'b1) begin errors++; $display("FAIL zw_valid[%0d]: got %b want 1", i, fs_o_valid); end
            checks++; if (fs_o_pc !== 32'(4 * i)) begin errors++; $display("FAIL zw_pc[%0d]: got %h want %h", i, fs_o_pc, 32'(4 * i)); end
            checks++; if (fs_o_instr !== 32'(4 * i + 256)) begin errors++; $display("FAIL zw_instr[%0d]: got %h want %h", i, fs_o_instr, 32'(4 * i + 256)); end
        end
    endtask

    task automatic test_backpressure();
        int idx, n;
        do_reset(1'b1, 1'b1, 0);
        repeat (3) @(negedge fs_clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge fs_clk);
            checks++; if (fs_o_imem_req !== 1'b0) begin errors++; $display("FAIL bp_req[%0d]: got %b want 0", i, fs_o_imem_req); end
            checks++; if (fs_o_valid !== 1'b1 || fs_o_pc !== 32'h0) begin errors++; $display("FAIL bp_head[%0d]: got valid=%b pc=%h want valid=1 pc=0", i, fs_o_valid, fs_o_pc); end
        end
        @(posedge fs_clk);
        #1;
        fs_i_stall = 1'b0;
        idx = 0;
        n = 0;
        while (idx < 3 && n < 20) begin
            @(negedge fs_clk);
            n++;
            if (fs_o_valid) begin
                checks++; if (fs_o_pc !== 32'(4 * idx)) begin errors++; $display("FAIL bp_order[%0d]: got %h want %h", idx, fs_o_pc, 32'(4 * idx)); end
                idx++;
            end
        end
        checks++; if (idx != 3) begin errors++; $display("FAIL bp_drain: got %0d entries want 3", idx); end
    endtask

    task automatic test_redirect_outstanding();
        int n;
        do_reset(1'b1, 1'b0, 3);
        n = 0;
        do @(negedge fs_clk); while (!(fs_o_imem_req && fs_i_imem_ack && fs_o_imem_addr == 32'h4) && ++n < 40);
        checks++; if (n >= 40) begin errors++; $display("FAIL ro_ack4: got no ack for addr 4 want one within 40 cycles"); end
        @(posedge fs_clk);
        #1;
        fs_i_stall = 1'b1;
        @(negedge fs_clk);
        checks++; if (fs_o_valid !== 1'b1 || fs_o_pc !== 32'h4) begin errors++; $display("FAIL ro_held: got valid=%b pc=%h want valid=1 pc=4", fs_o_valid, fs_o_pc); end
        @(posedge fs_clk);
        #1;
        fs_i_change_pc = 1'b1;
        fs_i_alu_pc = 32'h40;
        @(posedge fs_clk);
        #1;
        fs_i_change_pc = 1'b0;
        fs_i_stall = 1'b0;
        @(negedge fs_clk);
        checks++; if (fs_o_flush !== 1'b1) begin errors++; $display("FAIL ro_flush: got %b want 1", fs_o_flush); end
        checks++; if (fs_o_valid !== 1'b0) begin errors++; $display("FAIL ro_empty: got %b want 0", fs_o_valid); end
        checks++; if (fs_o_imem_req !== 1'b1 || fs_o_imem_addr !== 32'h8) begin errors++; $display("FAIL ro_drop: got req=%b addr=%h want req=1 addr=8", fs_o_imem_req, fs_o_imem_addr); end
        @(negedge fs_clk);
        checks++; if (fs_o_flush !== 1'b0) begin errors++; $display("FAIL ro_flush_end: got %b want 0", fs_o_flush); end
        n = 0;
        do @(negedge fs_clk); while (!(fs_o_imem_req && fs_o_imem_addr != 32'h8) && ++n < 40);
        checks++; if (fs_o_imem_addr !== 32'h40) begin errors++; $display("FAIL ro_new_addr: got %h want 40", fs_o_imem_addr); end
        n = 0;
        do @(negedge fs_clk); while (!fs_o_valid && ++n < 40);
        checks++; if (fs_o_pc !== 32'h40 || fs_o_instr !== 32'h140) begin errors++; $display("FAIL ro_first: got pc=%h instr=%h want pc=40 instr=140", fs_o_pc, fs_o_instr); end
    endtask

    task automatic test_redirect_ack(input logic st);
        int n;
        do_reset(1'b1, st, 1);
        n = 0;
        do @(negedge fs_clk); while (!(fs_o_imem_req && fs_o_imem_addr == 32'h4 && !fs_i_imem_ack) && ++n < 40);
        checks++; if (n >= 40) begin errors++; $display("FAIL ra_req4[st=%b]: got no request for addr 4 want one", st); end
        @(posedge fs_clk);
        #1;
        fs_i_change_pc = 1'b1;
        fs_i_alu_pc = 32'h80;
        @(posedge fs_clk);
        #1;
        fs_i_change_pc = 1'b0;
        @(negedge fs_clk);
        checks++; if (fs_o_flush !== 1'b1) begin errors++; $display("FAIL ra_flush[st=%b]: got %b want 1", st, fs_o_flush); end
        checks++; if (fs_o_valid !== 1'b0) begin errors++; $display("FAIL ra_empty[st=%b]: got %b want 0", st, fs_o_valid); end
        checks++; if (fs_o_imem_req !== 1'b0) begin errors++; $display("FAIL ra_idle[st=%b]: got %b want 0", st, fs_o_imem_req); end
        n = 0;
        do @(negedge fs_clk); while (!fs_o_valid && ++n < 40);
        checks++; if (fs_o_pc !== 32'h80 || fs_o_instr !== 32'h180) begin errors++; $display("FAIL ra_first[st=%b]: got pc=%h instr=%h want pc=80 instr=180", st, fs_o_pc, fs_o_instr); end
        @(posedge fs_clk);
        #1;
        fs_i_stall = 1'b0;
    endtask

    task automatic test_ce_wrap();
        int idx, n;
        logic [31:0] want;
        do_reset(1'b1, 1'b0, 2);
        n = 0;
        do @(negedge fs_clk); while (!(fs_o_imem_req && !fs_i_imem_ack) && ++n < 40);
        @(posedge fs_clk);
        #1;
        fs_i_ce = 1'b0;
        n = 0;
        do @(negedge fs_clk); while (!(fs_o_imem_req && fs_i_imem_ack) && ++n < 40);
        checks++; if (n >= 40) begin errors++; $display("FAIL ce_ack: got no ack want one after ce low"); end
        @(negedge fs_clk);
        checks++; if (fs_o_valid !== 1'b1 || fs_o_pc !== 32'h0) begin errors++; $display("FAIL ce_accept: got valid=%b pc=%h want valid=1 pc=0", fs_o_valid, fs_o_pc); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (fs_o_imem_req !== 1'b0) begin errors++; $display("FAIL ce_idle[%0d]: got %b want 0", i, fs_o_imem_req); end
            @(negedge fs_clk);
        end
        @(posedge fs_clk);
        #1;
        fs_i_change_pc = 1'b1;
        fs_i_alu_pc = 32'hFFFF_FFFC;
        @(posedge fs_clk);
        #1;
        fs_i_change_pc = 1'b0;
        fs_i_ce = 1'b1;
        mem_lat = 0;
        idx = 0;
        n = 0;
        while (idx < 2 && n < 30) begin
            @(negedge fs_clk);
            n++;
            if (fs_o_valid) begin
                want = idx == 0 ? 32'hFFFF_FFFC : 32'h0;
                checks++; if (fs_o_pc !== want || fs_o_instr !== want + 32'h100) begin errors++; $display("FAIL wrap[%0d]: got pc=%h instr=%h want pc=%h instr=%h", idx, fs_o_pc, fs_o_instr, want, want + 32'h100); end
                idx++;
            end
        end
        checks++; if (idx != 2) begin errors++; $display("FAIL wrap_count: got %0d entries want 2", idx); end
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        do @(negedge fs_clk); while (!(fs_o_imem_req && fs_o_valid && fs_o_pc != 32'h0) && ++n < 40);
        checks++; if (n >= 40) begin errors++; $display("FAIL rm_busy: got idle want streaming before reset"); end
        #2;
        fs_rst = 1'b0;
        #1;
        checks++; if (fs_o_imem_req !== 1'b0) begin errors++; $display("FAIL rm_req: got %b want 0", fs_o_imem_req); end
        checks++; if (fs_o_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b want 0", fs_o_valid); end
        checks++; if (fs_o_flush !== 1'b0) begin errors++; $display("FAIL rm_flush: got %b want 0", fs_o_flush); end
        checks++; if (fs_o_imem_addr !== 32'h0) begin errors++; $display("FAIL rm_addr: got %h want 0", fs_o_imem_addr); end
        checks++; if (fs_o_pc !== 32'h0 || fs_o_instr !== 32'h0) begin errors++; $display("FAIL rm_out: got pc=%h instr=%h want 0 0", fs_o_pc, fs_o_instr); end
        @(posedge fs_clk);
        #1;
        fs_i_ce = 1'b0;
        fs_rst = 1'b1;
        repeat (2) @(negedge fs_clk);
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_redirect_outstanding();
        test_redirect_ack(1'b0);
        test_redirect_ack(1'b1);
        test_ce_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
